branch_resolve_unit: RTL and testbench

Parametrised successor to the single-port branch flush logic. Accepts resolved branches from up to `NUM_BR_PORTS` execute channels each cycle, detects mispredictions against the prediction carried with each branch, and selects the oldest mispredicting branch by ROB age. It then drives a registered, multi-cycle flush/redirect to fetch and the ROB. It also owns a 2-bit-counter branch history table (BHT) that fetch reads combinationally and that every resolved branch trains.

---
 rtl/branch_resolve_unit_pkg.sv | 46 ++++
 rtl/branch_resolve_unit_bht.sv | 57 +++++
 rtl/branch_resolve_unit.sv | 173 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for branch resolution: next-PC select, per-port
// resolution bundle, BHT reset constant and counter step helper.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package branch_resolve_unit_pkg;

   localparam int A_W       = `INST_ADDR_WIDTH;
   localparam int MAX_TAG_W = 16;

   localparam logic [1:0] BHT_WEAK_NT = 2'b01;

   typedef enum logic [1:0] {
      pc_plus_4_t = 2'd0,
      sb          = 2'd1,
      uj          = 2'd2,
      jalr_t      = 2'd3
   } next_pc_t;

   // Tags are zero-extended to MAX_TAG_W so one struct serves any TAG_W.
   typedef struct packed {
      logic                 valid;
      logic                 is_branch;
      logic                 taken;
      logic [A_W-1:0]       pc;
      logic [A_W-1:0]       target;
      logic                 pred_taken;
      logic [A_W-1:0]       pred_target;
      logic [MAX_TAG_W-1:0] rob_tag;
   } br_res_t;

   function automatic logic [1:0] ctr_step(
      input logic [1:0] c,
      input logic       up
   );
      logic [1:0] r;
      r = c;
      if (up && c != 2'b11)
         r = c + 2'b01;
      else if (!up && c != 2'b00)
         r = c - 2'b01;
      return r;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// bht_2bit: 2-bit saturating counter table, one read port and
// NUM_PORTS training ports; ports sharing an index: oldest trains.
// Ports: clk, rst_n, rd_idx/rd_taken (lookup), wr_en/wr_idx/
// wr_taken/wr_age (training, age smaller = older).
module bht_2bit
   import branch_resolve_unit_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = 6,
   parameter int AGE_W     = 5
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [IDX_W-1:0]                 rd_idx,
   output logic                             rd_taken,
   input  logic [NUM_PORTS-1:0]             wr_en,
   input  logic [NUM_PORTS-1:0][IDX_W-1:0]  wr_idx,
   input  logic [NUM_PORTS-1:0]             wr_taken,
   input  logic [NUM_PORTS-1:0][AGE_W-1:0]  wr_age
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0]           ctr_q [DEPTH];
   logic [NUM_PORTS-1:0] wr_win;

   // A port loses its write when another live port on the same
   // index is older, or equally old with a lower port number.
   always_comb begin
      wr_win = wr_en;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int q = 0; q < NUM_PORTS; q++) begin
            if (q != p && wr_en[q] &&
                wr_idx[q] == wr_idx[p] &&
                (wr_age[q] < wr_age[p] ||
                 (wr_age[q] == wr_age[p] && q < p)))
               wr_win[p] = 1'b0;
         end
      end
   end

   assign rd_taken = ctr_q[rd_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            ctr_q[i] <= BHT_WEAK_NT;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_win[p])
               ctr_q[wr_idx[p]] <=
                  ctr_step(ctr_q[wr_idx[p]], wr_taken[p]);
         end
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-port branch resolution: oldest mispredict select, timed
// flush/redirect FSM, saturating mispredict count and BHT training.
// Ports: clk, rst_n, per-port br_* resolution inputs, rob_head,
// fetch_pc/fetch_pred_taken, flush, flush_rob_tag, pc_out,
// next_pc_sel, mispred_cnt.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int NUM_BR_PORTS = 2,
   parameter int TAG_W        = 5,
   parameter int BHT_IDX_W    = 6,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_BR_PORTS-1:0]             br_valid,
   input  logic [NUM_BR_PORTS-1:0]             is_branch_op,
   input  logic [NUM_BR_PORTS-1:0]             branch_taken,
   input  logic [NUM_BR_PORTS-1:0][A_W-1:0]    br_pc,
   input  logic [NUM_BR_PORTS-1:0][A_W-1:0]    br_target,
   input  logic [NUM_BR_PORTS-1:0]             pred_taken,
   input  logic [NUM_BR_PORTS-1:0][A_W-1:0]    pred_target,
   input  logic [NUM_BR_PORTS-1:0][TAG_W-1:0]  br_rob_tag,
   input  logic [TAG_W-1:0]                    rob_head,
   input  logic [A_W-1:0]                      fetch_pc,
   output logic                                fetch_pred_taken,
   output logic                                flush,
   output logic [TAG_W-1:0]                    flush_rob_tag,
   output logic [A_W-1:0]                      pc_out,
   output next_pc_t                            next_pc_sel,
   output logic [31:0]                         mispred_cnt
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   br_res_t                         res [NUM_BR_PORTS];
   logic [NUM_BR_PORTS-1:0]         live;
   logic [NUM_BR_PORTS-1:0]         mis;
   logic [NUM_BR_PORTS-1:0][TAG_W-1:0] age;
   logic [NUM_BR_PORTS-1:0][A_W-1:0]   fix_pc;
   logic [NUM_BR_PORTS-1:0][BHT_IDX_W-1:0] bht_idx;

   logic             win_vld;
   logic [TAG_W-1:0] win_age;
   logic [TAG_W-1:0] win_tag;
   logic [A_W-1:0]   win_pc;
   logic [TAG_W-1:0] cap_age;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [A_W-1:0]   pc_q, pc_d;
   logic [31:0]      mcnt_q;
   logic             cap;

   always_comb begin
      for (int p = 0; p < NUM_BR_PORTS; p++) begin
         res[p].valid       = br_valid[p];
         res[p].is_branch   = is_branch_op[p];
         res[p].taken       = branch_taken[p];
         res[p].pc          = br_pc[p];
         res[p].target      = br_target[p];
         res[p].pred_taken  = pred_taken[p];
         res[p].pred_target = pred_target[p];
         res[p].rob_tag     = MAX_TAG_W'(br_rob_tag[p]);
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_BR_PORTS; p++) begin
         live[p] = res[p].valid && res[p].is_branch;
         mis[p]  = live[p] &&
                   ((res[p].taken != res[p].pred_taken) ||
                    (res[p].taken &&
                     res[p].target != res[p].pred_target));
         age[p]  = res[p].rob_tag[TAG_W-1:0] - rob_head;
         fix_pc[p] = res[p].taken ? res[p].target
                                  : res[p].pc + A_W'(4);
         bht_idx[p] = res[p].pc[BHT_IDX_W+1:2];
      end
   end

   // Strict compare keeps the lower port on equal age.
   always_comb begin
      win_vld = 1'b0;
      win_age = '0;
      win_tag = '0;
      win_pc  = '0;
      for (int p = 0; p < NUM_BR_PORTS; p++) begin
         if (mis[p] && (!win_vld || age[p] < win_age)) begin
            win_vld = 1'b1;
            win_age = age[p];
            win_tag = res[p].rob_tag[TAG_W-1:0];
            win_pc  = fix_pc[p];
         end
      end
   end

   assign cap_age = tag_q - rob_head;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      pc_d    = pc_q;
      cap     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (win_vld)
               cap = 1'b1;
         end
         ST_FLUSH: begin
            if (win_vld && win_age < cap_age)
               cap = 1'b1;
            else if (cnt_q <= CNT_W'(1))
               state_d = ST_IDLE;
            else
               cnt_d = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      if (cap) begin
         state_d = ST_FLUSH;
         cnt_d   = CNT_W'(FLUSH_CYCLES);
         tag_d   = win_tag;
         pc_d    = win_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tag_q   <= '0;
         pc_q    <= '0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         pc_q    <= pc_d;
         if (cap && mcnt_q != 32'hFFFF_FFFF)
            mcnt_q <= mcnt_q + 32'd1;
      end
   end

   assign flush         = (state_q == ST_FLUSH);
   assign flush_rob_tag = tag_q;
   assign pc_out        = pc_q;
   assign next_pc_sel   = flush ? sb : pc_plus_4_t;
   assign mispred_cnt   = mcnt_q;

   bht_2bit #(
      .NUM_PORTS (NUM_BR_PORTS),
      .IDX_W     (BHT_IDX_W),
      .AGE_W     (TAG_W)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (fetch_pc[BHT_IDX_W+1:2]),
      .rd_taken (fetch_pred_taken),
      .wr_en    (live),
      .wr_idx   (bht_idx),
      .wr_taken (branch_taken),
      .wr_age   (age)
   );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: redirect scoreboard,
// flush timing, oldest select, wrap-around ages and BHT training.
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0]          br_valid, is_branch_op;
   logic [1:0]          branch_taken, pred_taken;
   logic [1:0][A_W-1:0] br_pc, br_target, pred_target;
   logic [1:0][4:0]     br_rob_tag;
   logic [4:0]          rob_head;
   logic [A_W-1:0]      fetch_pc;
   logic                fetch_pred_taken, flush;
   logic [4:0]          flush_rob_tag;
   logic [A_W-1:0]      pc_out;
   next_pc_t            next_pc_sel;
   logic [31:0]         mispred_cnt;

   typedef struct {
      logic [4:0]     tag;
      logic [A_W-1:0] pc;
   } exp_t;

   exp_t sb_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .br_valid         (br_valid),
      .is_branch_op     (is_branch_op),
      .branch_taken     (branch_taken),
      .br_pc            (br_pc),
      .br_target        (br_target),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .br_rob_tag       (br_rob_tag),
      .rob_head         (rob_head),
      .fetch_pc         (fetch_pc),
      .fetch_pred_taken (fetch_pred_taken),
      .flush            (flush),
      .flush_rob_tag    (flush_rob_tag),
      .pc_out           (pc_out),
      .next_pc_sel      (next_pc_sel),
      .mispred_cnt      (mispred_cnt)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ports();
      br_valid     = '0;
      is_branch_op = '0;
      branch_taken = '0;
      pred_taken   = '0;
      br_pc        = '0;
      br_target    = '0;
      pred_target  = '0;
      br_rob_tag   = '0;
   endtask

   task automatic set_port(input int p,
                           input logic tk,
                           input logic [A_W-1:0] pc,
                           input logic [A_W-1:0] tgt,
                           input logic pt,
                           input logic [A_W-1:0] ptgt,
                           input logic [4:0] tag);
      br_valid[p]     = 1'b1;
      is_branch_op[p] = 1'b1;
      branch_taken[p] = tk;
      br_pc[p]        = pc;
      br_target[p]    = tgt;
      pred_taken[p]   = pt;
      pred_target[p]  = ptgt;
      br_rob_tag[p]   = tag;
   endtask

   task automatic push_exp(input logic [4:0] tag,
                           input logic [A_W-1:0] pc);
      exp_t e;
      e.tag = tag;
      e.pc  = pc;
      sb_q.push_back(e);
   endtask

   // Monitor: a new redirect is a rising flush or a changed
   // tag/pc while flushing; each one pops the scoreboard.
   logic           flush_d;
   logic [4:0]     tag_d;
   logic [A_W-1:0] pc_d;

   always @(negedge clk) begin
      if (!rst_n) begin
         flush_d = 1'b0;
      end else begin
         if (flush && (!flush_d || flush_rob_tag != tag_d ||
                       pc_out != pc_d)) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_tag", 64'(flush_rob_tag), 64'(e.tag));
               check("sb_pc", 64'(pc_out), 64'(e.pc));
            end
         end
         flush_d = flush;
      end
      tag_d = flush_rob_tag;
      pc_d  = pc_out;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      rob_head = '0;
      fetch_pc = '0;
      clear_ports();
      #12;
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_tag", 64'(flush_rob_tag), 64'd0);
      check("rst_pc", 64'(pc_out), 64'd0);
      check("rst_sel", 64'(next_pc_sel), 64'(pc_plus_4_t));
      check("rst_cnt", 64'(mispred_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic: predicted NT, taken to 0x100, tag 3
      set_port(0, 1'b1, 32'h10, 32'h100, 1'b0, 32'h0, 5'd3);
      push_exp(5'd3, 32'h100);
      tick();
      clear_ports();
      check("t1_flush", 64'(flush), 64'd1);
      check("t1_pc", 64'(pc_out), 64'h100);
      check("t1_tag", 64'(flush_rob_tag), 64'd3);
      check("t1_sel", 64'(next_pc_sel), 64'(sb));
      check("t1_cnt", 64'(mispred_cnt), 64'd1);
      tick();
      check("t1_flush2", 64'(flush), 64'd1);
      tick();
      check("t1_flush_end", 64'(flush), 64'd0);
      check("t1_sel_end", 64'(next_pc_sel),
            64'(pc_plus_4_t));
      check("t1_pc_hold", 64'(pc_out), 64'h100);

      // Both mispredict, p1 older
      rob_head = 5'd1;
      set_port(0, 1'b1, 32'h200, 32'h300, 1'b0, 32'h0, 5'd6);
      set_port(1, 1'b1, 32'h204, 32'h400, 1'b0, 32'h0, 5'd2);
      push_exp(5'd2, 32'h400);
      tick();
      clear_ports();
      check("t2_tag", 64'(flush_rob_tag), 64'd2);
      check("t2_cnt", 64'(mispred_cnt), 64'd2);
      tick(); tick();

      // Wrap-around: head 30, p1 tag 31 (age 1) beats p0 tag 1
      rob_head = 5'd30;
      set_port(0, 1'b1, 32'h300, 32'h500, 1'b0, 32'h0, 5'd1);
      set_port(1, 1'b1, 32'h304, 32'h600, 1'b0, 32'h0, 5'd31);
      push_exp(5'd31, 32'h600);
      tick();
      clear_ports();
      check("t3_tag", 64'(flush_rob_tag), 64'd31);
      check("t3_pc", 64'(pc_out), 64'h600);
      tick(); tick();

      // Predicted taken, actually not taken at 0x40
      rob_head = 5'd0;
      set_port(0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h200, 5'd9);
      push_exp(5'd9, 32'h44);
      tick();
      clear_ports();
      check("t4_pc", 64'(pc_out), 64'h44);
      check("t4_cnt", 64'(mispred_cnt), 64'd4);
      tick(); tick();

      // Direction right, target wrong
      set_port(1, 1'b1, 32'h500, 32'h904, 1'b1, 32'h900, 5'd8);
      push_exp(5'd8, 32'h904);
      tick();
      clear_ports();
      check("t5_flush", 64'(flush), 64'd1);
      check("t5_pc", 64'(pc_out), 64'h904);
      tick(); tick();

      // Correct prediction and non-branch op: no redirect
      set_port(0, 1'b1, 32'h600, 32'hA00, 1'b1, 32'hA00, 5'd4);
      set_port(1, 1'b1, 32'h604, 32'hB00, 1'b0, 32'h0, 5'd3);
      is_branch_op[1] = 1'b0;
      tick();
      clear_ports();
      check("t6_flush", 64'(flush), 64'd0);
      check("t6_cnt", 64'(mispred_cnt), 64'd5);

      // Older re-capture extends flush, younger ignored
      set_port(0, 1'b1, 32'h700, 32'h700, 1'b0, 32'h0, 5'd5);
      push_exp(5'd5, 32'h700);
      tick();
      clear_ports();
      check("t7_tag5", 64'(flush_rob_tag), 64'd5);
      set_port(1, 1'b1, 32'h704, 32'h800, 1'b0, 32'h0, 5'd4);
      push_exp(5'd4, 32'h800);
      tick();
      clear_ports();
      check("t7_re_pc", 64'(pc_out), 64'h800);
      check("t7_re_tag", 64'(flush_rob_tag), 64'd4);
      check("t7_re_cnt", 64'(mispred_cnt), 64'd7);
      set_port(0, 1'b1, 32'h708, 32'h900, 1'b0, 32'h0, 5'd7);
      tick();
      clear_ports();
      check("t7_ext_flush", 64'(flush), 64'd1);
      check("t7_yng_pc", 64'(pc_out), 64'h800);
      check("t7_yng_tag", 64'(flush_rob_tag), 64'd4);
      check("t7_yng_cnt", 64'(mispred_cnt), 64'd7);
      tick();
      check("t7_end", 64'(flush), 64'd0);

      // Reset mid-flush drops everything at once
      set_port(0, 1'b1, 32'h800, 32'hA00, 1'b0, 32'h0, 5'd2);
      push_exp(5'd2, 32'hA00);
      tick();
      clear_ports();
      tick();
      check("t8_flush", 64'(flush), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t8_rst_flush", 64'(flush), 64'd0);
      check("t8_rst_pc", 64'(pc_out), 64'd0);
      check("t8_rst_tag", 64'(flush_rob_tag), 64'd0);
      check("t8_rst_sel", 64'(next_pc_sel),
            64'(pc_plus_4_t));
      check("t8_rst_cnt", 64'(mispred_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // BHT index 0x10 (pc 0x40), correctly predicted ops
      fetch_pc = 32'h40;
      #1;
      check("bht_init", 64'(fetch_pred_taken), 64'd0);
      for (int i = 0; i < 3; i++) begin
         set_port(0, 1'b1, 32'h40, 32'h1000, 1'b1,
                  32'h1000, 5'd1);
         #1;
         if (i == 0)
            check("bht_nobypass", 64'(fetch_pred_taken), 64'd0);
         tick();
         clear_ports();
         check("bht_taken", 64'(fetch_pred_taken), 64'd1);
      end
      set_port(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 5'd1);
      tick();
      clear_ports();
      check("bht_nt1", 64'(fetch_pred_taken), 64'd1);
      set_port(0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 5'd1);
      tick();
      clear_ports();
      check("bht_nt2", 64'(fetch_pred_taken), 64'd0);
      set_port(0, 1'b1, 32'h40, 32'h1000, 1'b1, 32'h1000, 5'd1);
      tick();
      clear_ports();
      check("bht_retake", 64'(fetch_pred_taken), 64'd1);
      check("bht_noflush", 64'(flush), 64'd0);

      // Same index on both ports: only the oldest trains
      fetch_pc = 32'h80;
      set_port(0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0, 5'd3);
      set_port(1, 1'b1, 32'h80, 32'h1100, 1'b1, 32'h1100, 5'd1);
      tick();
      clear_ports();
      check("bht_merge_p1", 64'(fetch_pred_taken), 64'd1);
      set_port(0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0, 5'd1);
      set_port(1, 1'b1, 32'h80, 32'h1100, 1'b1, 32'h1100, 5'd3);
      tick();
      clear_ports();
      check("bht_merge_p0", 64'(fetch_pred_taken), 64'd0);

      // Reset restores BHT to weakly not-taken
      fetch_pc = 32'h40;
      #1;
      check("bht_pre_rst", 64'(fetch_pred_taken), 64'd1);
      rst_n = 1'b0;
      #1;
      check("bht_rst", 64'(fetch_pred_taken), 64'd0);
      check("bht_rst_flush", 64'(flush), 64'd0);
      check("bht_rst_cnt", 64'(mispred_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
